// File: rtl/ldtu_ostream_rx.sv
// Receive side of the LiTe-DTU output stream: locks on idles, strips protocol words, buffers payload.
// Optional LDTU_RX_STATS_EN builds the saturating word_cnt/drop_cnt counters (tied to 0 otherwise).
module ldtu_ostream_rx #(
    parameter logic [31:0] IDLE_PATTERN  = 32'hEAAAAAAA,
    parameter logic [31:0] FLUSH_PATTERN = 32'h2CF0F0F0,
    parameter int          LOCK_IDLES    = 4,
    parameter int          FifoDepth     = 16,
    parameter int          bits_ptr      = 4
) (
    input  logic        CLK,
    input  logic        rst_b,
    input  logic [31:0] DATA32_DTU,
    input  logic [31:0] synch_pattern,
    input  logic        synch_en,
    input  logic        rd_en,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        empty,
    output logic        full,
    output logic        locked,
    output logic        flush_seen,
    output logic        synch_seen,
    output logic        overflow,
    output logic [15:0] word_cnt,
    output logic [15:0] drop_cnt,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {HUNT = 2'd0, LOCKED = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [bits_ptr:0] DEPTH_C = FifoDepth[bits_ptr:0];
    localparam logic [3:0]        LOCK_C  = LOCK_IDLES[3:0];

    state_t              state;
    logic [31:0]         w_q;
    logic [3:0]          idle_cnt;
    logic [31:0]         mem [FifoDepth];
    logic [bits_ptr-1:0] wr_ptr, rd_ptr;
    logic [bits_ptr:0]   count;
    logic                is_flush, is_idle, is_synch, is_payload;
    logic                rd_ok, wr_ok, drop, flush_entry;

    always_comb begin
        is_flush   = (w_q == FLUSH_PATTERN);
        is_idle    = !is_flush && (w_q == IDLE_PATTERN);
        is_synch   = !is_flush && !is_idle && synch_en && (w_q == synch_pattern);
        is_payload = !is_flush && !is_idle && !is_synch;
    end

    // Read handshake: rd_en is a request; it is accepted only when the buffer is non-empty,
    // and an accepted read returns data_out with a data_valid pulse at the same edge.
    assign rd_ok       = rd_en && !empty;
    // A full buffer still takes a word when a read frees a slot in the same cycle.
    assign wr_ok       = (state == LOCKED) && is_payload && (!full || rd_ok);
    assign drop        = (state == LOCKED) && is_payload && !wr_ok;
    assign flush_entry = is_flush && (state != FLUSH);

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign locked    = (state == LOCKED);
    assign fsm_state = state;

    always_ff @(posedge CLK) begin
        if (rst_b && wr_ok) mem[wr_ptr] <= w_q;
    end

    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            state      <= HUNT;
            w_q        <= IDLE_PATTERN;
            idle_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            flush_seen <= 1'b0;
            synch_seen <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            w_q        <= DATA32_DTU;
            data_valid <= rd_ok;
            flush_seen <= 1'b0;
            synch_seen <= 1'b0;
            if (rd_ok) data_out <= mem[rd_ptr];

            if (flush_entry) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                overflow   <= 1'b0;
                flush_seen <= 1'b1;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
                if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
                count <= count + {{bits_ptr{1'b0}}, wr_ok} - {{bits_ptr{1'b0}}, rd_ok};
                if (drop) overflow <= 1'b1;
            end

            case (state)
                HUNT: begin
                    if (is_flush) begin
                        state    <= FLUSH;
                        idle_cnt <= '0;
                    end else if (is_idle) begin
                        if (idle_cnt + 4'd1 >= LOCK_C) begin
                            state    <= LOCKED;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 4'd1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (is_flush) state <= FLUSH;
                    if (is_synch) synch_seen <= 1'b1;
                end
                FLUSH: begin
                    // The word that ends the flush already counts toward the next lock.
                    if (!is_flush) begin
                        state    <= HUNT;
                        idle_cnt <= is_idle ? 4'd1 : 4'd0;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

`ifdef LDTU_RX_STATS_EN
    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            word_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (wr_ok && word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign word_cnt = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ldtu_ostream_rx.sv
// Bench for ldtu_ostream_rx: lock table, directed corner sequences and random traffic vs a queue model.
module tb_ldtu_ostream_rx;
  localparam logic [31:0] IDLE = 32'hEAAAAAAA;
  localparam logic [31:0] FLSH = 32'h2CF0F0F0;
  localparam int LOCK_N = 4;
  localparam int DEPTH = 16;
`ifdef LDTU_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        rst_b = 1'b0;
  logic [31:0] DATA32_DTU = '0;
  logic [31:0] synch_pattern = 32'h5A5A5A5A;
  logic        synch_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] data_out;
  logic        data_valid, empty, full, locked, flush_seen, synch_seen, overflow;
  logic [15:0] word_cnt, drop_cnt;
  logic [1:0]  fsm_state;

  always #5 CLK = ~CLK;

  ldtu_ostream_rx dut (
    .CLK(CLK), .rst_b(rst_b), .DATA32_DTU(DATA32_DTU), .synch_pattern(synch_pattern),
    .synch_en(synch_en), .rd_en(rd_en), .data_out(data_out), .data_valid(data_valid),
    .empty(empty), .full(full), .locked(locked), .flush_seen(flush_seen),
    .synch_seen(synch_seen), .overflow(overflow), .word_cnt(word_cnt), .drop_cnt(drop_cnt),
    .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the stream rules applied to a queue.
  typedef enum int {M_HUNT, M_LOCKED, M_FLUSH} mstate_t;
  logic [31:0] exp_q[$];
  mstate_t     m_state;
  int          m_idle, m_word, m_drop;
  logic [31:0] m_wq, m_data;
  bit          m_valid, m_fp, m_sp, m_ovf;

  typedef struct {
    logic [31:0] word;
    logic        rd;
    logic        exp_locked;
    logic        exp_empty;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [31:0] word, input logic rd);
    bit rd_ok, f, i, s;
    if (!rst_b) begin
      exp_q.delete();
      m_state = M_HUNT; m_idle = 0; m_word = 0; m_drop = 0;
      m_wq = IDLE; m_data = '0; m_valid = 0; m_fp = 0; m_sp = 0; m_ovf = 0;
      return;
    end
    m_fp = 0; m_sp = 0;
    rd_ok = rd && (exp_q.size() != 0);
    m_valid = rd_ok;
    if (rd_ok) m_data = exp_q.pop_front();
    f = (m_wq == FLSH);
    i = !f && (m_wq == IDLE);
    s = !f && !i && synch_en && (m_wq == synch_pattern);
    case (m_state)
      M_HUNT: begin
        if (f) begin
          m_state = M_FLUSH; m_idle = 0; exp_q.delete(); m_ovf = 0; m_fp = 1;
        end else if (i) begin
          m_idle++;
          if (m_idle >= LOCK_N) begin m_state = M_LOCKED; m_idle = 0; end
        end else m_idle = 0;
      end
      M_LOCKED: begin
        if (f) begin
          m_state = M_FLUSH; exp_q.delete(); m_ovf = 0; m_fp = 1;
        end else if (s) m_sp = 1;
        else if (!i) begin
          if (exp_q.size() < DEPTH) begin
            exp_q.push_back(m_wq);
            if (m_word < 65535) m_word++;
          end else begin
            m_ovf = 1;
            if (m_drop < 65535) m_drop++;
          end
        end
      end
      default: begin
        if (!f) begin m_state = M_HUNT; m_idle = i ? 1 : 0; end
      end
    endcase
    m_wq = word;
  endtask

  task automatic check_model();
    check("m_data_out", data_out, m_data);
    check("m_data_valid", data_valid, m_valid);
    check("m_empty", empty, exp_q.size() == 0);
    check("m_full", full, exp_q.size() == DEPTH);
    check("m_locked", locked, m_state == M_LOCKED);
    check("m_flush_seen", flush_seen, m_fp);
    check("m_synch_seen", synch_seen, m_sp);
    check("m_overflow", overflow, m_ovf);
    check("m_word_cnt", word_cnt, STATS ? m_word : 0);
    check("m_drop_cnt", drop_cnt, STATS ? m_drop : 0);
  endtask

  task automatic tick(input logic [31:0] word, input logic rd);
    DATA32_DTU = word;
    rd_en = rd;
    @(posedge CLK);
    model_edge(word, rd);
    #1;
    check_model();
  endtask

  task automatic do_lock();
    rst_b = 1'b0;
    tick(32'h0, 1'b0);
    rst_b = 1'b1;
    tick(32'h0, 1'b0);
    repeat (LOCK_N + 1) tick(IDLE, 1'b0);
    check("lock_helper", locked, 1'b1);
  endtask

  initial begin
    int n, first_at, n_rd;
    logic [31:0] w;

    // Reset: the first word after release is non-idle so the reset-value idle does not count.
    vecs[0] = '{32'h0, 1'b0, 1'b0, 1'b1};
    for (int k = 1; k <= 3; k++) vecs[k] = '{IDLE, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h12345678, 1'b0, 1'b0, 1'b1};
    for (int k = 5; k <= 8; k++) vecs[k] = '{IDLE, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{IDLE, 1'b0, 1'b1, 1'b1};

    rst_b = 1'b0;
    tick(32'h0, 1'b0);
    tick(32'h0, 1'b0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_word_cnt", word_cnt, 16'h0);
    check("rst_drop_cnt", drop_cnt, 16'h0);
    rst_b = 1'b1;

    for (int k = 0; k < 10; k++) begin
      tick(vecs[k].word, vecs[k].rd);
      check($sformatf("tbl_locked_%0d", k), locked, vecs[k].exp_locked);
      check($sformatf("tbl_empty_%0d", k), empty, vecs[k].exp_empty);
    end

    // Payload with reads: first word valid two edges after its input edge.
    do_lock();
    n = 0; first_at = -1;
    for (int k = 0; k < 7; k++) begin
      tick(k < 3 ? 32'hA0000001 + k : IDLE, 1'b1);
      if (data_valid) begin
        if (first_at < 0) first_at = k;
        check("pay_data", data_out, 32'hA0000001 + n);
        n++;
      end
    end
    check("pay_latency", first_at, 2);
    check("pay_count", n, 3);
    check("pay_word_cnt", word_cnt, STATS ? 3 : 0);

    // Overflow: 18 words into a 16-deep buffer, then drain.
    do_lock();
    for (int k = 0; k < 18; k++) tick(32'hB0000001 + k, 1'b0);
    tick(IDLE, 1'b0);
    check("ovf_full", full, 1'b1);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_drop_cnt", drop_cnt, STATS ? 2 : 0);
    check("ovf_word_cnt", word_cnt, STATS ? 16 : 0);
    for (int k = 0; k < 16; k++) begin
      tick(IDLE, 1'b1);
      check("ovf_rd_valid", data_valid, 1'b1);
      check("ovf_rd_data", data_out, 32'hB0000001 + k);
    end
    check("ovf_empty", empty, 1'b1);
    tick(IDLE, 1'b1);
    check("empty_rd_valid", data_valid, 1'b0);
    check("empty_rd_hold", data_out, 32'hB0000010);

    // Flush clears buffer and overflow, then relock.
    do_lock();
    for (int k = 0; k < 17; k++) tick(32'hC1000000 + k, 1'b0);
    tick(IDLE, 1'b0);
    check("fl_pre_overflow", overflow, 1'b1);
    n = 0;
    tick(FLSH, 1'b0); n += int'(flush_seen);
    tick(FLSH, 1'b0); n += int'(flush_seen);
    check("fl_locked", locked, 1'b0);
    check("fl_empty", empty, 1'b1);
    check("fl_overflow", overflow, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick(IDLE, 1'b0); n += int'(flush_seen);
    end
    check("fl_not_yet", locked, 1'b0);
    tick(IDLE, 1'b0); n += int'(flush_seen);
    check("fl_pulses", n, 1);
    check("fl_relock", locked, 1'b1);

    // Synch word dropped when enabled, buffered when disabled.
    synch_pattern = 32'h5A5A5A5A;
    synch_en = 1'b1;
    do_lock();
    n = 0;
    tick(32'h5A5A5A5A, 1'b0); n += int'(synch_seen);
    for (int k = 0; k < 3; k++) begin
      tick(IDLE, 1'b0); n += int'(synch_seen);
    end
    check("sy_pulses", n, 1);
    check("sy_empty", empty, 1'b1);
    synch_en = 1'b0;
    tick(32'h5A5A5A5A, 1'b0);
    tick(IDLE, 1'b0);
    check("sy_off_empty", empty, 1'b0);
    tick(IDLE, 1'b1);
    check("sy_off_data", data_out, 32'h5A5A5A5A);

    // Read and write together at full, across pointer wrap.
    do_lock();
    n_rd = 0;
    for (int k = 0; k < 36; k++) begin
      tick(32'hC0000000 + k, k >= 17);
      if (k >= 16) begin
        check("fw_full", full, 1'b1);
        check("fw_overflow", overflow, 1'b0);
      end
      if (data_valid) begin
        check("fw_order", data_out, 32'hC0000000 + n_rd);
        n_rd++;
      end
    end
    check("fw_reads", n_rd, 19);

    // Random traffic in segments.
    do_lock();
    for (int seg = 0; seg < 150; seg++) begin
      int r, bias, len;
      r = $urandom_range(0, 99);
      bias = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) synch_en = ~synch_en;
      if (r < 15) begin
        repeat (5) tick(IDLE, $urandom_range(0, 3) < bias);
      end else if (r < 19) begin
        repeat ($urandom_range(1, 2)) tick(FLSH, $urandom_range(0, 1));
      end else if (r < 21) begin
        rst_b = 1'b0;
        tick(32'h0, 1'b0);
        rst_b = 1'b1;
      end else if (r < 30) begin
        tick(synch_pattern, $urandom_range(0, 3) < bias);
      end else begin
        len = $urandom_range(1, 12);
        for (int k = 0; k < len; k++) begin
          w = $urandom;
          tick(w, $urandom_range(0, 3) < bias);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
